// File: rtl/mesh_interface_unit_if.sv
// Shared NoC packet types and the mesh-link bundle of mesh_interface_unit.
package satswarmv2_pkg;
    localparam int CORE_ID_W = 4;

    typedef logic [1:0] msg_type_t;
    localparam msg_type_t MSG_NONE    = 2'd0;
    localparam msg_type_t MSG_DIVERGE = 2'd1;
    localparam msg_type_t MSG_CLAUSE  = 2'd2;
    localparam msg_type_t MSG_STATUS  = 2'd3;

    typedef struct packed {
        msg_type_t            msg_type;
        logic [CORE_ID_W-1:0] src_id;
        logic [7:0]           quality_metric;
        logic [63:0]          payload;
    } noc_packet_t;

    // Only DIVERGE and CLAUSE survive the RX filter, so a queued entry
    // needs one kind bit instead of the full header.
    typedef struct packed {
        logic        is_div;
        logic [7:0]  qm;
        logic [63:0] payload;
    } rx_entry_t;
endpackage

// Mesh links: master is the unit side, slave is the neighbour side.
interface mesh_interface_unit_if #(parameter int NUM_PORTS = 4);
    import satswarmv2_pkg::*;

    noc_packet_t [NUM_PORTS-1:0] rx_pkt;
    logic        [NUM_PORTS-1:0] rx_valid;
    logic        [NUM_PORTS-1:0] rx_ready;
    noc_packet_t [NUM_PORTS-1:0] tx_pkt;
    logic        [NUM_PORTS-1:0] tx_valid;
    logic        [NUM_PORTS-1:0] tx_ready;

    modport master (input rx_pkt, rx_valid, tx_ready, output rx_ready, tx_pkt, tx_valid);
    modport slave  (output rx_pkt, rx_valid, tx_ready, input rx_ready, tx_pkt, tx_valid);
endinterface

// File: rtl/mesh_interface_unit.sv
// NoC packet handler for one SAT core: filtered per-port RX FIFOs,
// round-robin delivery per class, and a registered multi-port TX launcher.

// Per-port RX queue; caller guarantees no push when full, no pop when empty.
module mesh_rx_fifo import satswarmv2_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  rx_entry_t din,
    input  logic      pop,
    output rx_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int PW = $clog2(DEPTH);

    rx_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; empty entries are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

module mesh_interface_unit import satswarmv2_pkg::*; #(
    parameter int CORE_ID    = 0,
    parameter int CORE_ID_W  = satswarmv2_pkg::CORE_ID_W,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LBD_LIMIT  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mesh_interface_unit_if.master mesh,
    input  logic                  diverge_req,
    input  logic [NUM_PORTS-1:0]  diverge_target,
    input  logic signed [31:0]    diverge_lit,
    output logic                  diverge_ack,
    input  logic                  clause_bcast_req,
    input  logic [7:0]            clause_lbd,
    input  logic [63:0]           clause_ptr,
    output logic                  clause_bcast_ack,
    output logic                  force_valid,
    output logic signed [31:0]    force_lit,
    input  logic                  force_ready,
    output logic                  clause_rx_valid,
    output logic [7:0]            clause_rx_lbd,
    output logic [63:0]           clause_rx_ptr,
    input  logic                  clause_rx_ready,
    output logic [15:0]           drop_cnt
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CORE_ID_W-1:0] CORE_ID_V = CORE_ID_W'(CORE_ID);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] CLS  = 2'd2;

    logic      [NUM_PORTS-1:0] full, empty, accept, drop, push, pop;
    rx_entry_t [NUM_PORTS-1:0] head;
    rx_entry_t [NUM_PORTS-1:0] din;
    logic      [NUM_PORTS-1:0] head_div, head_cls;
    logic [PW-1:0]             rr_div, rr_cls, div_win, cls_win;
    logic [16:0]               drop_sum;

    logic [1:0]                  state;
    logic [NUM_PORTS-1:0]        pending, tx_vld, tx_fire;
    noc_packet_t [NUM_PORTS-1:0] tx_pkt_q;
    noc_packet_t                 div_pkt, cls_pkt;

    assign mesh.rx_ready = ~full;
    assign mesh.tx_valid = tx_vld;
    assign mesh.tx_pkt   = tx_pkt_q;

    // RX filter: classify each accepted packet as queued or dropped.
    always_comb begin
        accept = '0;
        drop   = '0;
        push   = '0;
        din    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            accept[i] = mesh.rx_valid[i] & ~full[i];
            drop[i]   = accept[i] &
                        ((mesh.rx_pkt[i].src_id == CORE_ID_V) ||
                         (mesh.rx_pkt[i].msg_type == MSG_CLAUSE &&
                          mesh.rx_pkt[i].quality_metric > 8'(LBD_LIMIT)) ||
                         (mesh.rx_pkt[i].msg_type != MSG_CLAUSE &&
                          mesh.rx_pkt[i].msg_type != MSG_DIVERGE));
            push[i]           = accept[i] & ~drop[i];
            din[i].is_div     = (mesh.rx_pkt[i].msg_type == MSG_DIVERGE);
            din[i].qm         = mesh.rx_pkt[i].quality_metric;
            din[i].payload    = mesh.rx_pkt[i].payload;
            head_div[i]       = ~empty[i] &  head[i].is_div;
            head_cls[i]       = ~empty[i] & ~head[i].is_div;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rx
        mesh_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .din   (din[g]),
            .pop   (pop[g]),
            .head  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // Round-robin search per class: first matching head at or after the pointer.
    always_comb begin
        int idx;
        logic div_found, cls_found;
        idx       = 0;
        div_found = 1'b0;
        cls_found = 1'b0;
        div_win   = '0;
        cls_win   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(rr_div) + k) % NUM_PORTS;
            if (!div_found && head_div[idx]) begin
                div_found = 1'b1;
                div_win   = PW'(idx);
            end
            idx = (int'(rr_cls) + k) % NUM_PORTS;
            if (!cls_found && head_cls[idx]) begin
                cls_found = 1'b1;
                cls_win   = PW'(idx);
            end
        end
    end

    assign force_valid     = |head_div;
    assign clause_rx_valid = |head_cls;
    assign force_lit       = force_valid ? head[div_win].payload[31:0] : '0;
    assign clause_rx_ptr   = clause_rx_valid ? head[cls_win].payload : '0;
    assign clause_rx_lbd   = clause_rx_valid ? head[cls_win].qm : '0;

    // Pop the granted head of each class; the two winners are always distinct ports.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            pop[i] = (force_valid && force_ready && div_win == PW'(i)) ||
                     (clause_rx_valid && clause_rx_ready && cls_win == PW'(i));
    end

    // Advance each class pointer past its winner on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_div <= '0;
            rr_cls <= '0;
        end else begin
            if (force_valid && force_ready)
                rr_div <= (div_win == PW'(NUM_PORTS-1)) ? '0 : div_win + 1'b1;
            if (clause_rx_valid && clause_rx_ready)
                rr_cls <= (cls_win == PW'(NUM_PORTS-1)) ? '0 : cls_win + 1'b1;
        end
    end

    // Several ports may drop in one cycle; add the popcount and clamp.
    always_comb begin
        drop_sum = {1'b0, drop_cnt};
        for (int i = 0; i < NUM_PORTS; i++) drop_sum = drop_sum + 17'(drop[i]);
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                drop_cnt <= '0;
        else if (drop_sum[16])     drop_cnt <= 16'hFFFF;
        else                       drop_cnt <= drop_sum[15:0];
    end

    assign tx_fire = tx_vld & mesh.tx_ready;
    assign div_pkt = '{msg_type: MSG_DIVERGE, src_id: CORE_ID_V,
                       quality_metric: 8'd0, payload: {32'd0, diverge_lit}};
    assign cls_pkt = '{msg_type: MSG_CLAUSE, src_id: CORE_ID_V,
                       quality_metric: clause_lbd, payload: clause_ptr};

    // TX launcher: capture a request in IDLE, retire ports independently, ack when all done.
    // Requests are ignored during the ack cycle because the requester is still holding them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pending          <= '0;
            tx_vld           <= '0;
            tx_pkt_q         <= '0;
            diverge_ack      <= 1'b0;
            clause_bcast_ack <= 1'b0;
        end else begin
            diverge_ack      <= 1'b0;
            clause_bcast_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (!diverge_ack && !clause_bcast_ack) begin
                        if (diverge_req) begin
                            if (diverge_target != '0) begin
                                for (int i = 0; i < NUM_PORTS; i++)
                                    if (diverge_target[i]) tx_pkt_q[i] <= div_pkt;
                                tx_vld  <= diverge_target;
                                pending <= diverge_target;
                                state   <= DIV;
                            end else begin
                                diverge_ack <= 1'b1;
                            end
                        end else if (clause_bcast_req) begin
                            for (int i = 0; i < NUM_PORTS; i++) tx_pkt_q[i] <= cls_pkt;
                            tx_vld  <= '1;
                            pending <= '1;
                            state   <= CLS;
                        end
                    end
                end
                DIV, CLS: begin
                    tx_vld  <= tx_vld & ~tx_fire;
                    pending <= pending & ~tx_fire;
                    if ((pending & ~tx_fire) == '0) begin
                        state <= IDLE;
                        if (state == DIV) diverge_ack      <= 1'b1;
                        else              clause_bcast_ack <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mesh_interface_unit.sv
// Directed bench for mesh_interface_unit: RX filtering, FIFO backpressure,
// round-robin delivery, TX broadcast/divergence and reset abort.
module tb_mesh_interface_unit;
    import satswarmv2_pkg::*;

    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mesh_interface_unit_if #(.NUM_PORTS(NP)) mesh ();

    logic              diverge_req = 1'b0;
    logic [NP-1:0]     diverge_target = '0;
    logic signed [31:0] diverge_lit = '0;
    logic              diverge_ack;
    logic              clause_bcast_req = 1'b0;
    logic [7:0]        clause_lbd = '0;
    logic [63:0]       clause_ptr = '0;
    logic              clause_bcast_ack;
    logic              force_valid;
    logic signed [31:0] force_lit;
    logic              force_ready = 1'b0;
    logic              clause_rx_valid;
    logic [7:0]        clause_rx_lbd;
    logic [63:0]       clause_rx_ptr;
    logic              clause_rx_ready = 1'b0;
    logic [15:0]       drop_cnt;

    mesh_interface_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mesh             (mesh),
        .diverge_req      (diverge_req),
        .diverge_target   (diverge_target),
        .diverge_lit      (diverge_lit),
        .diverge_ack      (diverge_ack),
        .clause_bcast_req (clause_bcast_req),
        .clause_lbd       (clause_lbd),
        .clause_ptr       (clause_ptr),
        .clause_bcast_ack (clause_bcast_ack),
        .force_valid      (force_valid),
        .force_lit        (force_lit),
        .force_ready      (force_ready),
        .clause_rx_valid  (clause_rx_valid),
        .clause_rx_lbd    (clause_rx_lbd),
        .clause_rx_ptr    (clause_rx_ptr),
        .clause_rx_ready  (clause_rx_ready),
        .drop_cnt         (drop_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic noc_packet_t mk(input msg_type_t t, input logic [CORE_ID_W-1:0] s,
                                       input logic [7:0] q, input logic [63:0] p);
        mk = '{msg_type: t, src_id: s, quality_metric: q, payload: p};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mesh.rx_valid = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    noc_packet_t exp_pkt;

    initial begin
        mesh.rx_pkt   = '0;
        mesh.rx_valid = '0;
        mesh.tx_ready = '0;
        step();
        do_reset();

        // reset state
        chk("rst_tx_valid", 128'(mesh.tx_valid), 128'(4'h0));
        chk("rst_tx_pkt0", 128'(mesh.tx_pkt[0]), 128'(0));
        chk("rst_rx_ready", 128'(mesh.rx_ready), 128'(4'hF));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(16'h0));
        chk("rst_acks", 128'({diverge_ack, clause_bcast_ack}), 128'(2'b00));
        chk("rst_force_valid", 128'(force_valid), 128'(1'b0));

        // single DIVERGE on port 2, visible one cycle after acceptance
        mesh.rx_pkt[2] = mk(MSG_DIVERGE, 4'd3, 8'd0, 64'hFFFF_FFF9);
        mesh.rx_valid[2] = 1'b1;
        chk("div_not_yet", 128'(force_valid), 128'(1'b0));
        step();
        mesh.rx_valid[2] = 1'b0;
        chk("div_valid", 128'(force_valid), 128'(1'b1));
        chk("div_lit", 128'($unsigned(force_lit)), 128'(32'hFFFF_FFF9));
        force_ready = 1'b1;
        step();
        force_ready = 1'b0;
        chk("div_popped", 128'(force_valid), 128'(1'b0));
        chk("div_lit_zero", 128'($unsigned(force_lit)), 128'(32'h0));

        // fill port 1 with four clauses, 5th held but refused
        for (int k = 0; k < 4; k++) begin
            mesh.rx_pkt[1] = mk(MSG_CLAUSE, 4'd2, 8'd3, 64'hC0DE_0000_0000_0000 + 64'(k));
            mesh.rx_valid[1] = 1'b1;
            step();
        end
        chk("fill_full", 128'(mesh.rx_ready), 128'(4'b1101));
        chk("fill_cls_valid", 128'(clause_rx_valid), 128'(1'b1));
        chk("fill_head_ptr", 128'(clause_rx_ptr), 128'(64'hC0DE_0000_0000_0000));
        chk("fill_head_lbd", 128'(clause_rx_lbd), 128'(8'd3));
        mesh.rx_pkt[1] = mk(MSG_CLAUSE, 4'd2, 8'd3, 64'hC0DE_0000_0000_0099);
        step();
        chk("fill_still_full", 128'(mesh.rx_ready[1]), 128'(1'b0));
        mesh.rx_valid[1] = 1'b0;
        clause_rx_ready = 1'b1;
        step();
        chk("fill_ready_back", 128'(mesh.rx_ready[1]), 128'(1'b1));
        chk("fill_ptr1", 128'(clause_rx_ptr), 128'(64'hC0DE_0000_0000_0001));
        step();
        chk("fill_ptr2", 128'(clause_rx_ptr), 128'(64'hC0DE_0000_0000_0002));
        step();
        chk("fill_ptr3", 128'(clause_rx_ptr), 128'(64'hC0DE_0000_0000_0003));
        step();
        chk("fill_no_5th", 128'(clause_rx_valid), 128'(1'b0));
        clause_rx_ready = 1'b0;

        // filtering: high LBD, self-loop, unknown type dropped; LBD at the limit kept
        mesh.rx_pkt[0] = mk(MSG_CLAUSE, 4'd1, 8'd9, 64'h1);
        mesh.rx_pkt[1] = mk(MSG_CLAUSE, 4'd0, 8'd2, 64'h2);
        mesh.rx_pkt[2] = mk(MSG_STATUS, 4'd1, 8'd0, 64'h3);
        mesh.rx_pkt[3] = mk(MSG_CLAUSE, 4'd1, 8'd8, 64'hBEEF);
        mesh.rx_valid = 4'hF;
        step();
        mesh.rx_valid = '0;
        chk("flt_drop_cnt", 128'(drop_cnt), 128'(16'd3));
        chk("flt_no_force", 128'(force_valid), 128'(1'b0));
        chk("flt_lbd8_valid", 128'(clause_rx_valid), 128'(1'b1));
        chk("flt_lbd8_ptr", 128'(clause_rx_ptr), 128'(64'hBEEF));
        chk("flt_lbd8_lbd", 128'(clause_rx_lbd), 128'(8'd8));
        clause_rx_ready = 1'b1;
        step();
        clause_rx_ready = 1'b0;
        chk("flt_drained", 128'(clause_rx_valid), 128'(1'b0));

        // saturation: four self-loop drops per cycle
        for (int i = 0; i < NP; i++) mesh.rx_pkt[i] = mk(MSG_DIVERGE, 4'd0, 8'd0, 64'h0);
        mesh.rx_valid = 4'hF;
        for (int c = 0; c < 16382; c++) step();
        chk("sat_pre", 128'(drop_cnt), 128'(16'hFFFB));
        mesh.rx_valid = 4'b0111;
        step();
        chk("sat_near", 128'(drop_cnt), 128'(16'hFFFE));
        mesh.rx_valid = 4'hF;
        step();
        chk("sat_clamp", 128'(drop_cnt), 128'(16'hFFFF));
        for (int c = 0; c < 1200; c++) step();
        mesh.rx_valid = '0;
        chk("sat_hold", 128'(drop_cnt), 128'(16'hFFFF));
        chk("sat_no_force", 128'(force_valid), 128'(1'b0));

        // round-robin divergence delivery from a fresh pointer
        do_reset();
        mesh.rx_pkt[0] = mk(MSG_DIVERGE, 4'd1, 8'd0, 64'hA0);
        mesh.rx_pkt[3] = mk(MSG_DIVERGE, 4'd1, 8'd0, 64'hA3);
        mesh.rx_valid = 4'b1001;
        force_ready = 1'b1;
        step();
        mesh.rx_valid = '0;
        chk("rr1_first", 128'($unsigned(force_lit)), 128'(32'hA0));
        step();
        chk("rr1_second", 128'($unsigned(force_lit)), 128'(32'hA3));
        step();
        chk("rr1_done", 128'(force_valid), 128'(1'b0));
        force_ready = 1'b0;
        mesh.rx_pkt[0] = mk(MSG_DIVERGE, 4'd1, 8'd0, 64'hB0);
        mesh.rx_pkt[3] = mk(MSG_DIVERGE, 4'd1, 8'd0, 64'hB3);
        mesh.rx_valid = 4'b1001;
        step();
        mesh.rx_valid = '0;
        chk("rr2_wrapped", 128'($unsigned(force_lit)), 128'(32'hB0));
        force_ready = 1'b1;
        step();
        force_ready = 1'b0;
        mesh.rx_pkt[0] = mk(MSG_DIVERGE, 4'd1, 8'd0, 64'hC0);
        mesh.rx_valid = 4'b0001;
        step();
        mesh.rx_valid = '0;
        chk("rr3_port3_first", 128'($unsigned(force_lit)), 128'(32'hB3));
        force_ready = 1'b1;
        step();
        chk("rr3_port0_next", 128'($unsigned(force_lit)), 128'(32'hC0));
        step();
        force_ready = 1'b0;
        chk("rr3_empty", 128'(force_valid), 128'(1'b0));

        // DIVERGE at a head hides a clause queued behind it; both classes can coexist
        mesh.rx_pkt[1] = mk(MSG_DIVERGE, 4'd1, 8'd0, 64'h11);
        mesh.rx_valid = 4'b0010;
        step();
        mesh.rx_pkt[1] = mk(MSG_CLAUSE, 4'd1, 8'd4, 64'h22);
        mesh.rx_pkt[2] = mk(MSG_CLAUSE, 4'd1, 8'd5, 64'h33);
        mesh.rx_valid = 4'b0110;
        step();
        mesh.rx_valid = '0;
        chk("hol_both_valid", 128'({force_valid, clause_rx_valid}), 128'(2'b11));
        chk("hol_cls_from_p2", 128'(clause_rx_ptr), 128'(64'h33));
        clause_rx_ready = 1'b1;
        step();
        clause_rx_ready = 1'b0;
        chk("hol_cls_blocked", 128'(clause_rx_valid), 128'(1'b0));
        force_ready = 1'b1;
        step();
        force_ready = 1'b0;
        chk("hol_cls_released", 128'(clause_rx_ptr), 128'(64'h22));
        clause_rx_ready = 1'b1;
        step();
        clause_rx_ready = 1'b0;

        // clause broadcast with partial acceptance
        clause_lbd = 8'd5;
        clause_ptr = 64'h1234_5678_9ABC_DEF0;
        clause_bcast_req = 1'b1;
        exp_pkt = mk(MSG_CLAUSE, 4'd0, 8'd5, 64'h1234_5678_9ABC_DEF0);
        step();
        chk("bc_launch", 128'(mesh.tx_valid), 128'(4'hF));
        chk("bc_pkt2", 128'(mesh.tx_pkt[2]), 128'(exp_pkt));
        mesh.tx_ready = 4'b0101;
        step();
        chk("bc_partial", 128'(mesh.tx_valid), 128'(4'b1010));
        step();
        step();
        chk("bc_partial_hold", 128'(mesh.tx_valid), 128'(4'b1010));
        chk("bc_pkt1_stable", 128'(mesh.tx_pkt[1]), 128'(exp_pkt));
        chk("bc_pkt3_stable", 128'(mesh.tx_pkt[3]), 128'(exp_pkt));
        chk("bc_no_early_ack", 128'(clause_bcast_ack), 128'(1'b0));
        mesh.tx_ready = 4'hF;
        step();
        chk("bc_all_done", 128'(mesh.tx_valid), 128'(4'h0));
        chk("bc_ack", 128'(clause_bcast_ack), 128'(1'b1));
        clause_bcast_req = 1'b0;
        step();
        chk("bc_ack_one_cycle", 128'(clause_bcast_ack), 128'(1'b0));
        chk("bc_no_relaunch", 128'(mesh.tx_valid), 128'(4'h0));

        // divergence with an empty target mask acks without sending
        diverge_req = 1'b1;
        diverge_target = '0;
        step();
        chk("d0_ack", 128'(diverge_ack), 128'(1'b1));
        chk("d0_no_tx", 128'(mesh.tx_valid), 128'(4'h0));
        diverge_req = 1'b0;
        step();
        chk("d0_ack_drop", 128'(diverge_ack), 128'(1'b0));

        // divergence outranks a simultaneous clause request
        mesh.tx_ready = '0;
        diverge_req = 1'b1;
        diverge_target = 4'b1000;
        diverge_lit = -32'sd100;
        clause_bcast_req = 1'b1;
        clause_lbd = 8'd2;
        clause_ptr = 64'hFEED_0000_0000_0001;
        step();
        chk("pri_div_only_p3", 128'(mesh.tx_valid), 128'(4'b1000));
        chk("pri_div_pkt", 128'(mesh.tx_pkt[3]),
            128'(mk(MSG_DIVERGE, 4'd0, 8'd0, 64'h0000_0000_FFFF_FF9C)));
        mesh.tx_ready = 4'b1000;
        step();
        mesh.tx_ready = '0;
        chk("pri_div_ack", 128'({diverge_ack, clause_bcast_ack}), 128'(2'b10));
        diverge_req = 1'b0;
        step();
        chk("pri_gap", 128'(mesh.tx_valid), 128'(4'h0));
        step();
        chk("pri_cls_launch", 128'(mesh.tx_valid), 128'(4'hF));
        chk("pri_cls_pkt0", 128'(mesh.tx_pkt[0]),
            128'(mk(MSG_CLAUSE, 4'd0, 8'd2, 64'hFEED_0000_0000_0001)));
        mesh.tx_ready = 4'b0001;
        step();
        mesh.tx_ready = '0;
        chk("abort_partial", 128'(mesh.tx_valid), 128'(4'b1110));

        // asynchronous reset mid-broadcast
        #2 rst_n = 1'b0;
        #1 chk("abort_tx_cleared", 128'(mesh.tx_valid), 128'(4'h0));
        clause_bcast_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        mesh.tx_ready = 4'hF;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("abort_no_ack", 128'({diverge_ack, clause_bcast_ack, mesh.tx_valid}), 128'(6'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mesh_interface_unit.md
Name: mesh_interface_unit

Overview:
- Parametrised NoC packet handler for one SAT core: NUM_PORTS mesh links, per-port RX FIFOs, round-robin arbitration with divergence over clause priority, and registered TX with per-port delivery tracking.
- Sits between the core's divergence/clause-sharing logic and the mesh links.
- Adds three things a single-slot handler lacks:
  - buffering, so a busy core does not stall neighbours;
  - self-loop and LBD filtering;
  - partial-acceptance broadcast, where each port completes independently and ack fires only when all targets are done.

Parameters:
CORE_ID, 0, this core's id; stamped into src_id of every TX packet.
CORE_ID_W, satswarmv2_pkg::CORE_ID_W, width of src_id.
NUM_PORTS, 4, number of mesh links; port index 0 has highest static rank.
FIFO_DEPTH, 4, entries per RX FIFO; power of two, >=2.
LBD_LIMIT, 8, clauses with quality_metric > LBD_LIMIT are dropped on receipt.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rx_pkt  in  NUM_PORTS x noc_packet_t  incoming packets
rx_valid  in  NUM_PORTS  incoming valid
rx_ready  out  NUM_PORTS  port can accept
tx_pkt  out  NUM_PORTS x noc_packet_t  outgoing packets (registered)
tx_valid  out  NUM_PORTS  outgoing valid (registered)
tx_ready  in  NUM_PORTS  neighbour accepts
diverge_req  in  1  request to send a divergence force
diverge_target  in  NUM_PORTS  target port mask
diverge_lit  in  32 signed  literal to force
diverge_ack  out  1  one-cycle pulse: all targets delivered
clause_bcast_req  in  1  request to broadcast a clause
clause_lbd  in  8  clause LBD
clause_ptr  in  64  clause pointer
clause_bcast_ack  out  1  one-cycle pulse: all ports delivered
force_valid  out  1  divergence force available
force_lit  out  32 signed  forced literal
force_ready  in  1  core consumes force
clause_rx_valid  out  1  received clause available
clause_rx_lbd  out  8  received clause LBD
clause_rx_ptr  out  64  received clause pointer
clause_rx_ready  in  1  core consumes clause
drop_cnt  out  16  saturating count of filtered packets

Behaviour:
Reset (async assert, sync deassert use):
- All FIFOs empty; RR pointers = 0; FSM IDLE; pending mask 0; drop_cnt 0.
- All tx_valid = 0, tx_pkt = '0; diverge_ack = 0; clause_bcast_ack = 0.
- rx_ready = all 1s on the first cycle after reset release.
- Reset mid-transfer discards queued and in-flight packets; no ack is issued.

RX path:
- rx_ready[i] = !full[i], from registered occupancy only; no combinational path from rx_valid.
- Handshake on rx_valid[i] & rx_ready[i]. The packet is accepted, then either enqueued or dropped:
  - src_id == CORE_ID: dropped (self-loop), drop_cnt++.
  - MSG_CLAUSE with quality_metric > LBD_LIMIT: dropped, drop_cnt++.
  - msg_type other than DIVERGE/CLAUSE: dropped, drop_cnt++.
  - Otherwise enqueued.
- drop_cnt saturates at 16'hFFFF. Multiple drops in one cycle add their popcount, clamped to the saturation value.
- Simultaneous enqueue and dequeue on a full FIFO: not possible, because ready is low when full. On a non-full FIFO both occur and occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Delivery arbitration (combinational from FIFO heads, registered state only):
- Divergence class: force_valid = 1 if any FIFO head is DIVERGE. Winner is the first such port at or after rr_div, wrapping.
- Clause class: clause_rx_valid = 1 if any FIFO head is CLAUSE. Winner is the first such port at or after rr_cls.
- Both classes can be valid together on different ports.
- If one port's head is DIVERGE, a clause further down that FIFO waits.
- On force_valid & force_ready: pop the winner; rr_div <= winner+1 mod NUM_PORTS. The clause class works the same way with rr_cls.
- Payload mapping: force_lit = payload[31:0]; clause_rx_ptr = payload; clause_rx_lbd = quality_metric.
- When a class is not valid, its outputs are '0.
- Latency: a packet accepted in cycle N is visible at the core interface in cycle N+1.

TX FSM (IDLE, DIV, CLS):
- IDLE:
  - diverge_req wins over clause_bcast_req.
  - On diverge_req with diverge_target != 0: load tx_pkt[i] for each target bit set (msg_type=MSG_DIVERGE, payload={32'd0, diverge_lit}, src_id=CORE_ID, quality_metric=0); set those tx_valid; pending=diverge_target; go to DIV.
  - diverge_req with diverge_target == 0: diverge_ack pulses the next cycle; no packet is sent; stay IDLE.
  - On clause_bcast_req (and no diverge_req): load all ports (msg_type=MSG_CLAUSE, payload=clause_ptr, quality_metric=clause_lbd, src_id=CORE_ID); pending=all 1s; go to CLS.
- DIV/CLS:
  - On tx_valid[i] & tx_ready[i]: clear tx_valid[i] and pending[i] next cycle.
  - tx_pkt[i] is held stable while tx_valid[i] is high.
  - When pending becomes 0: pulse diverge_ack or clause_bcast_ack for exactly one cycle; return to IDLE.
  - A new request is sampled from IDLE no earlier than the cycle after the ack.
- Requesters must hold req and data until ack. Inputs are captured at launch only.

Test Plan:
- Reset, then rx_valid[2] with a DIVERGE packet, src_id=3, payload=32'hFFFF_FFF9 → one cycle later force_valid=1, force_lit=-7; with force_ready=1, pops and force_valid=0 the next cycle.
- Fill port 1 with 4 CLAUSE packets, clause_rx_ready=0 → rx_ready[1]=0 after the 4th; rx_valid held on a 5th packet is not accepted; one pop → rx_ready[1]=1 the next cycle.
- Filtering: CLAUSE with quality_metric=9; CLAUSE with src_id=CORE_ID; msg_type other than DIVERGE/CLAUSE → all accepted, none delivered, drop_cnt=3. Force 70000 drops → drop_cnt=16'hFFFF.
- Round-robin: DIVERGE packets at ports 0 and 3 simultaneously, force_ready=1 constant → delivered order port 0 then port 3; refill both → port 0 served before port 3 again only after rr_div wraps (rr_div=0 after port 3 grant).
- Clause broadcast with tx_ready=4'b0101 for 3 cycles, then 4'b1111 → ports 0 and 2 deliver first, ports 1 and 3 later; tx_pkt stable throughout; clause_bcast_ack pulses once, one cycle after the last delivery.
- diverge_req and clause_bcast_req both asserted, target=4'b1000 → the divergence packet goes only to port 3, diverge_ack pulses, then the clause broadcast launches. Asserting rst_n=0 mid-broadcast → tx_valid=0 immediately and no ack.
